spc2: RTL
=========

# spc2

Parametrised serial-to-parallel configuration converter for the BIO IC configuration path. It receives a configuration frame over a three-wire pad interface (Sclk, Cfg_in, Strobe), oversamples all three lines on the single system clock, and transfers the frame to a parallel output word only when the frame length is correct. Compared with the previous generation it adds a configurable word width, frame-length checking with an error flag, and an optional serial readback/daisy-chain output.

## Interface
- WIDTH, 11: configuration word width in bits; must be 2 to 64.
- RESET_VALUE, 0: value of Cfg_word after reset; WIDTH bits.

- Clk  input  1  system clock; the only clock in the block.
- Reset  input  1  asynchronous, active-high reset; clears all state.
- Sclk  input  1  serial bit clock from pad, asynchronous to Clk.
- Cfg_in  input  1  serial data from pad, asynchronous to Clk.
- Strobe  input  1  frame-commit line from pad, asynchronous to Clk.
- Cfg_word  output  WIDTH  committed configuration word.
- Cfg_valid  output  1  one-Clk pulse when Cfg_word is updated.
- Frame_err  output  1  sticky; the last Strobe saw a bit count other than WIDTH.
- Cfg_out  output  1  serial readback bit; see Configuration.

## Operation
- Sclk, Cfg_in and Strobe each pass through a 2-flop synchroniser, followed by a third delay flop. Rise detect = stage2 & ~stage3. Cfg_in takes its value from stage2, so it stays aligned with the Sclk rise.
- Shift register sr[WIDTH-1:0], right shift. On an Sclk rise: sr <= {Cfg_in_s, sr[WIDTH-1:1]}. The first bit sent ends in bit 0 and the last bit sent in bit WIDTH-1.
- Bit counter cnt is ceil(log2(WIDTH+2)) bits wide. It increments on each Sclk rise and saturates at WIDTH+1.
- FSM states:
  - IDLE: cnt == 0.
  - SHIFT: 0 < cnt ≤ WIDTH.
  - OVER: cnt == WIDTH+1.
  - IDLE -> SHIFT on the first Sclk rise. SHIFT -> OVER on the (WIDTH+1)th rise. Any state -> IDLE on a Strobe rise.
- Strobe rise with cnt == WIDTH: Cfg_word <= sr, Cfg_valid = 1 for one cycle, Frame_err <= 0.
- Strobe rise with cnt != WIDTH: Cfg_word holds, Cfg_valid stays 0, Frame_err <= 1. This covers 0 bits, short frames and OVER.
- The shift register is not cleared by Strobe. Its contents stay available for readback.
- Sclk rise and Strobe rise detected in the same cycle:
  - Strobe is evaluated against the pre-shift sr and cnt.
  - The shift is discarded and cnt goes to 0.
- Reset, asynchronous, including mid-frame:
  - sr = 0, cnt = 0, FSM = IDLE, synchroniser flops = 0.
  - Cfg_word = RESET_VALUE, Cfg_valid = 0, Frame_err = 0, Cfg_out = 0.
- All outputs are registered.

## Timing
- Pad requirements:
  - Sclk high and low each ≥ 3 Clk periods.
  - Cfg_in stable ≥ 3 Clk before and ≥ 3 Clk after each Sclk rise.
  - Strobe high ≥ 3 Clk.
  - Strobe rises ≥ 3 Clk after the last Sclk rise. Closer spacing falls under the simultaneous-event rule above.
- Sclk pad rise to sr update: 3 Clk edges, plus up to 1 Clk of synchroniser uncertainty.
- Strobe pad rise to Cfg_word/Cfg_valid/Frame_err update: 3 Clk edges, plus up to 1 Clk.
- Cfg_valid is high for exactly one Clk per accepted frame. Cfg_word changes on that same edge.
- Cfg_out updates on the same Clk edge as the shift.

## Configuration
- Macro: SPC2_READBACK_EN.
- Defined:
  - Cfg_out is a register loaded with sr[0] on every shift, i.e. the bit shifted out.
  - Shifting a new frame therefore returns the previous frame, first bit first. This is used for write-verify and daisy-chaining spc2 instances.
  - Cfg_out is unchanged on Strobe.
- Undefined: Cfg_out is tied to 0, and no readback flop is synthesised.

## Test plan
- Good frame, WIDTH=11:
  - Stimulus: send bits 1,0,1,1,1,0,0,1,1,0,1, then Strobe.
  - Required: Cfg_word = 11'h59D, one Cfg_valid pulse, Frame_err = 0.
- Short frame:
  - Stimulus: after the good frame, send 10 bits, then Strobe.
  - Required: Frame_err = 1, no Cfg_valid, Cfg_word stays 11'h59D.
  - Then a correct 11-bit frame of all 1s -> Cfg_word = 11'h7FF, Frame_err = 0.
- Overflow frame:
  - Stimulus: send 13 bits, then Strobe.
  - Required: FSM passes through OVER, Frame_err = 1, Cfg_word unchanged.
  - Also: Strobe with no bits -> Frame_err = 1.
- Reset mid-frame:
  - Stimulus: pulse Reset after 6 bits.
  - Required: Cfg_word = RESET_VALUE, Frame_err = 0. A following full 11-bit frame loads correctly, with no stale bits counted.
- Simultaneous Sclk/Strobe rise:
  - Stimulus: send 11 bits; the 12th Sclk rise is detected in the same cycle as the Strobe rise.
  - Required: frame accepted with the first 11 bits, Cfg_valid pulses, cnt = 0 afterwards.
- Readback (SPC2_READBACK_EN):
  - Stimulus: after committing 11'h59D, shift 11 zeros.
  - Required: Cfg_out sequence 1,0,1,1,1,0,0,1,1,0,1.
  - Without the macro, Cfg_out stays 0 throughout.

Source files
------------

// File: rtl/spc2.sv
// spc2 - serial-to-parallel configuration converter.
//
// Oversamples a three-wire pad interface (Sclk, Cfg_in, Strobe) on Clk.
// Serial bits shift into sr. On a Strobe rise the frame is committed to
// Cfg_word only if exactly WIDTH bits were shifted. Otherwise Frame_err is
// set and stays set until the next accepted frame.
//
// Parameters
//   WIDTH        configuration word width (2..64)
//   RESET_VALUE  Cfg_word value after reset
// Ports
//   Clk, Reset   system clock, async active-high reset
//   Sclk         serial bit clock from pad (async)
//   Cfg_in       serial data from pad (async)
//   Strobe       frame-commit line from pad (async)
//   Cfg_word     committed configuration word
//   Cfg_valid    one-cycle pulse when Cfg_word is updated
//   Frame_err    sticky: the last Strobe saw a bit count other than WIDTH
//   Cfg_out      serial readback (bit shifted out of sr)
// Build option
//   SPC2_READBACK_EN  when defined, Cfg_out is a register loaded with sr[0]
//                     on every shift; when undefined, Cfg_out is tied to 0.
module spc2 #(
  parameter int              WIDTH       = 11,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Sclk,
  input  logic             Cfg_in,
  input  logic             Strobe,
  output logic [WIDTH-1:0] Cfg_word,
  output logic             Cfg_valid,
  output logic             Frame_err,
  output logic             Cfg_out
);

  localparam int             CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  // Synchronisers: bit0 = stage1, bit1 = stage2, bit2 = delay stage.
  // Data only needs two stages since it is sampled at stage2, in step with
  // the Sclk rise detect.
  logic [2:0] sclk_q, stb_q;
  logic [1:0] din_q;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic sclk_rise, stb_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign stb_rise  = stb_q[1]  & ~stb_q[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclk_q  <= '0;
      stb_q   <= '0;
      din_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= RESET_VALUE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], Sclk};
      stb_q   <= {stb_q[1:0], Strobe};
      din_q   <= {din_q[0], Cfg_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = err_q;
    if (stb_rise) begin
      // Strobe wins over a coincident Sclk rise: it is judged on the
      // pre-shift sr/cnt and that shift is dropped.
      state_d = IDLE;
      cnt_d   = '0;
      if (cnt_q == CNT_FULL) begin
        word_d  = sr_q;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (sclk_rise) begin
      sr_d = {din_q[1], sr_q[WIDTH-1:1]};
      unique case (state_q)
        IDLE:    state_d = SHIFT;
        SHIFT:   if (cnt_q == CNT_FULL) state_d = OVER;
        default: state_d = OVER;
      endcase
      // Count saturates at WIDTH+1, which is exactly the OVER state.
      if (state_q != OVER) cnt_d = cnt_q + 1'b1;
    end
  end

  assign Cfg_word  = word_q;
  assign Cfg_valid = valid_q;
  assign Frame_err = err_q;

`ifdef SPC2_READBACK_EN
  logic out_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                       out_q <= 1'b0;
    else if (sclk_rise && !stb_rise) out_q <= sr_q[0];
  end
  assign Cfg_out = out_q;
`else
  assign Cfg_out = 1'b0;
`endif

endmodule
